// File: rtl/edge_pkg.sv
// Shared defaults and the update record for the scatter update generator.
package edge_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;
  localparam int RD_LAT     = 2;

  typedef struct packed {
    logic [ADDR_W_DEF+5:0] dst;
    logic [DATA_W_DEF-1:0] val;
    logic                  last;
  } upd_rec_t;
endpackage

// File: rtl/update_fifo.sv
// Output queue for computed updates; head is presented combinationally.
module update_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [PW:0]      count_q;
  logic             do_pop;
  logic             do_push;

  assign do_pop  = pop && (count_q != '0);
  // A push into a full queue is legal only when the head leaves the same cycle.
  assign do_push = push && ((count_q != (PW+1)'(DEPTH)) || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_data = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count     = count_q;
endmodule

// File: rtl/scatter_update_gen.sv
// Turns edges into saturated vertex updates: read source value, add weight, queue.
module scatter_update_gen
  import edge_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W+5:0] edge_src,
  input  logic [ADDR_W+5:0] edge_dst,
  input  logic [DATA_W-1:0] edge_w,
  input  logic              edge_last,
  input  logic              edge_valid,
  output logic              edge_ready,
  output logic [ADDR_W+5:0] r_addr,
  input  logic [DATA_W-1:0] vval_in,
  output logic [ADDR_W+5:0] upd_dst,
  output logic [DATA_W-1:0] upd_val,
  output logic              upd_last,
  output logic              upd_valid,
  input  logic              upd_ready,
  output logic              idle
);
  localparam int VW    = ADDR_W + 6;
  localparam int NS    = RD_LAT + 1;
  localparam int IW    = $clog2(NS + 1);
  localparam int CW    = $clog2(FIFO_DEPTH) + 1;
  localparam int REC_W = VW + DATA_W + 1;

  logic              ready_en_q;
  logic [VW-1:0]     r_addr_q;
  logic              sh_vld_q  [NS];
  logic [VW-1:0]     sh_dst_q  [NS];
  logic [DATA_W-1:0] sh_w_q    [NS];
  logic              sh_last_q [NS];

  logic              accept;
  logic [IW-1:0]     inflight;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] sat_val;
  logic [REC_W-1:0]  push_data;
  logic [REC_W-1:0]  head_data;

  assign accept = edge_valid && edge_ready;

  // The shadow pipe is one stage longer than the read latency so that its
  // tail lines up with the cycle vval_in is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_en_q <= 1'b0;
      r_addr_q   <= '0;
      for (int i = 0; i < NS; i++) begin
        sh_vld_q[i]  <= 1'b0;
        sh_dst_q[i]  <= '0;
        sh_w_q[i]    <= '0;
        sh_last_q[i] <= 1'b0;
      end
    end else begin
      ready_en_q   <= 1'b1;
      if (accept) r_addr_q <= edge_src;
      sh_vld_q[0]  <= accept;
      sh_dst_q[0]  <= edge_dst;
      sh_w_q[0]    <= edge_w;
      sh_last_q[0] <= edge_last;
      for (int i = 1; i < NS; i++) begin
        sh_vld_q[i]  <= sh_vld_q[i-1];
        sh_dst_q[i]  <= sh_dst_q[i-1];
        sh_w_q[i]    <= sh_w_q[i-1];
        sh_last_q[i] <= sh_last_q[i-1];
      end
    end
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i < NS; i++) begin
      inflight = inflight + IW'(sh_vld_q[i]);
    end
  end

  // Credits count in-flight edges so the FIFO can never overflow.
  assign edge_ready = ready_en_q &&
                      (((CW+1)'(fifo_count) + (CW+1)'(inflight)) < (CW+1)'(FIFO_DEPTH));

  assign sum       = {1'b0, vval_in} + {1'b0, sh_w_q[NS-1]};
  assign sat_val   = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
  assign push_data = {sh_dst_q[NS-1], sat_val, sh_last_q[NS-1]};

  update_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (sh_vld_q[NS-1]),
    .push_data (push_data),
    .pop       (upd_valid && upd_ready),
    .head_data (head_data),
    .count     (fifo_count)
  );

  assign upd_valid = (fifo_count != '0);
  assign upd_dst   = head_data[REC_W-1 -: VW];
  assign upd_val   = head_data[DATA_W:1];
  assign upd_last  = head_data[0];
  assign r_addr    = r_addr_q;
  assign idle      = (inflight == '0) && (fifo_count == '0);
endmodule

// File: tb/tb_scatter_update_gen.sv
// Directed and randomised checks of scatter_update_gen against a 2-cycle memory model.
module tb_scatter_update_gen;
  import edge_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] edge_src, edge_dst, r_addr, upd_dst;
  logic [7:0]  edge_w, vval_in, upd_val;
  logic        edge_last, edge_valid, edge_ready;
  logic        upd_last, upd_valid, upd_ready, idle;
  logic [7:0]  mem_m1;

  int n_cmp = 0;
  int n_bad = 0;

  upd_rec_t acc_q[$];
  upd_rec_t obs_q[$];
  upd_rec_t tmp_acc, tmp_obs;

  scatter_update_gen dut (
    .clk(clk), .rst(rst), .edge_src(edge_src), .edge_dst(edge_dst), .edge_w(edge_w),
    .edge_last(edge_last), .edge_valid(edge_valid), .edge_ready(edge_ready),
    .r_addr(r_addr), .vval_in(vval_in), .upd_dst(upd_dst), .upd_val(upd_val),
    .upd_last(upd_last), .upd_valid(upd_valid), .upd_ready(upd_ready), .idle(idle)
  );

  always #5 clk = ~clk;

  // Memory holds value[v] = v[7:0]; two registered stages give read latency 2.
  always @(posedge clk) begin
    mem_m1  <= r_addr[7:0];
    vval_in <= mem_m1;
  end

  function automatic logic [7:0] exp_val(input logic [15:0] src, input logic [7:0] w);
    int s;
    s = int'(src[7:0]) + int'(w);
    return (s > 255) ? 8'd255 : 8'(s);
  endfunction

  always @(posedge clk) begin
    if (!rst && edge_valid && edge_ready) begin
      tmp_acc.dst  = edge_dst;
      tmp_acc.val  = exp_val(edge_src, edge_w);
      tmp_acc.last = edge_last;
      acc_q.push_back(tmp_acc);
    end
    if (!rst && upd_valid && upd_ready) begin
      tmp_obs.dst  = upd_dst;
      tmp_obs.val  = upd_val;
      tmp_obs.last = upd_last;
      obs_q.push_back(tmp_obs);
    end
  end

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic drive_edge(input logic [15:0] src, input logic [15:0] dst,
                            input logic [7:0] w, input logic last,
                            output bit ok, output int stalls);
    stalls     = 0;
    edge_src   = src;
    edge_dst   = dst;
    edge_w     = w;
    edge_last  = last;
    edge_valid = 1'b1;
    while (!edge_ready && stalls < 300) begin
      @(negedge clk);
      stalls++;
    end
    ok = edge_ready;
    if (ok) @(negedge clk);
    edge_valid = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    int n = 0;
    while (!idle && n < 1000) begin
      @(negedge clk);
      n++;
    end
    ok = idle;
  endtask

  task automatic test_reset;
    @(negedge clk);
    n_cmp++; if (edge_ready !== 1'b0) begin n_bad++; $display("FAIL rst_edge_ready got=%b want=0", edge_ready); end
    n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("FAIL rst_upd_valid got=%b want=0", upd_valid); end
    n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL rst_idle got=%b want=1", idle); end
    n_cmp++; if ({r_addr, upd_dst, upd_val, upd_last} !== 41'd0) begin
      n_bad++; $display("FAIL rst_outputs r_addr=%0d dst=%0d val=%0d last=%b want all 0", r_addr, upd_dst, upd_val, upd_last);
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (edge_ready !== 1'b0) begin n_bad++; $display("FAIL ready_before_edge got=%b want=0", edge_ready); end
    @(negedge clk);
    n_cmp++; if (edge_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after_edge got=%b want=1", edge_ready); end
    $display("test_reset done");
  endtask

  task automatic test_latency;
    bit ok;
    upd_ready = 1'b1;
    obs_q.delete(); acc_q.delete();
    edge_src = 16'd5; edge_dst = 16'd9; edge_w = 8'd3; edge_last = 1'b0; edge_valid = 1'b1;
    n_cmp++; if (edge_ready !== 1'b1) begin n_bad++; $display("FAIL lat_ready got=%b want=1", edge_ready); end
    @(negedge clk);
    edge_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (upd_valid !== 1'b0) begin n_bad++; $display("FAIL lat_early cycle=%0d got=%b want=0", i + 1, upd_valid); end
      @(negedge clk);
    end
    n_cmp++; if (upd_valid !== 1'b1 || upd_val !== 8'd8 || upd_dst !== 16'd9) begin
      n_bad++; $display("FAIL lat_3cyc valid=%b val=%0d dst=%0d want valid=1 val=8 dst=9", upd_valid, upd_val, upd_dst);
    end
    wait_idle(ok);
    n_cmp++; if (!ok || obs_q.size() != 1) begin n_bad++; $display("FAIL lat_count got=%0d want=1 idle=%b", obs_q.size(), ok); end
    $display("test_latency src=5 w=3 -> val=%0d dst=%0d", upd_val, upd_dst);
  endtask

  task automatic test_saturation;
    bit ok; int st;
    logic [7:0] ws [3] = '{8'd10, 8'd5, 8'd4};
    logic [7:0] ev [3] = '{8'd255, 8'd255, 8'd254};
    obs_q.delete(); acc_q.delete();
    for (int i = 0; i < 3; i++) drive_edge(16'd250, 16'(20 + i), ws[i], 1'b0, ok, st);
    wait_idle(ok);
    n_cmp++; if (obs_q.size() != 3) begin n_bad++; $display("FAIL sat_count got=%0d want=3", obs_q.size()); end
    for (int i = 0; i < 3 && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i].val !== ev[i] || obs_q[i].dst !== 16'(20 + i)) begin
        n_bad++; $display("FAIL sat_val w=%0d got=%0d dst=%0d want=%0d dst=%0d", ws[i], obs_q[i].val, obs_q[i].dst, ev[i], 20 + i);
      end
      $display("test_saturation src=250 w=%0d -> %0d", ws[i], obs_q[i].val);
    end
  endtask

  task automatic test_back_to_back;
    bit ok; int st; int tot = 0; int bad = 0;
    obs_q.delete(); acc_q.delete();
    for (int i = 0; i < 100; i++) begin
      drive_edge(16'(i * 3), 16'(i + 500), 8'(i * 5), (i == 99), ok, st);
      tot += st;
    end
    n_cmp++; if (tot != 0) begin n_bad++; $display("FAIL b2b_stalls got=%0d want=0", tot); end
    wait_idle(ok);
    n_cmp++; if (obs_q.size() != 100 || acc_q.size() != 100) begin
      n_bad++; $display("FAIL b2b_count got=%0d acc=%0d want=100", obs_q.size(), acc_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < acc_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== acc_q[i]) begin
        n_bad++; bad++; $display("FAIL b2b_item idx=%0d got=%h want=%h", i, obs_q[i], acc_q[i]);
      end
    end
    n_cmp++; if (obs_q.size() == 0 || obs_q[obs_q.size()-1].last !== 1'b1) begin
      n_bad++; $display("FAIL b2b_last final upd_last not set");
    end
    $display("test_back_to_back updates=%0d item_errors=%0d", obs_q.size(), bad);
  endtask

  task automatic test_backpressure;
    bit ok; int nacc = 0; int n = 0;
    logic [15:0] d0; logic [7:0] v0;
    obs_q.delete(); acc_q.delete();
    upd_ready = 1'b0;
    edge_valid = 1'b1; edge_src = 16'd300; edge_dst = 16'd1000; edge_w = 8'd0; edge_last = 1'b0;
    repeat (30) begin
      if (edge_ready) begin
        nacc++;
        @(negedge clk);
        edge_src = 16'(300 + nacc * 7); edge_dst = 16'(1000 + nacc); edge_w = 8'(nacc * 13);
      end else @(negedge clk);
    end
    n_cmp++; if (nacc != 8) begin n_bad++; $display("FAIL bp_accepted got=%0d want=8", nacc); end
    n_cmp++; if (edge_ready !== 1'b0 || upd_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_full ready=%b valid=%b want ready=0 valid=1", edge_ready, upd_valid);
    end
    d0 = upd_dst; v0 = upd_val;
    repeat (5) @(negedge clk);
    n_cmp++; if (upd_dst !== d0 || upd_val !== v0 || upd_valid !== 1'b1) begin
      n_bad++; $display("FAIL bp_stable dst=%0d val=%0d want dst=%0d val=%0d", upd_dst, upd_val, d0, v0);
    end
    n_cmp++; if (acc_q.size() == 0 || upd_dst !== acc_q[0].dst || upd_val !== acc_q[0].val) begin
      n_bad++; $display("FAIL bp_head dst=%0d val=%0d want first accepted", upd_dst, upd_val);
    end
    upd_ready = 1'b1;
    while (nacc < 12 && n < 100) begin
      if (edge_ready) begin
        nacc++;
        @(negedge clk);
        edge_src = 16'(300 + nacc * 7); edge_dst = 16'(1000 + nacc); edge_w = 8'(nacc * 13);
      end else @(negedge clk);
      n++;
    end
    edge_valid = 1'b0;
    n_cmp++; if (nacc != 12) begin n_bad++; $display("FAIL bp_resume accepted=%0d want=12", nacc); end
    wait_idle(ok);
    n_cmp++; if (obs_q.size() != 12) begin n_bad++; $display("FAIL bp_drain got=%0d want=12", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < acc_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== acc_q[i]) begin
        n_bad++; $display("FAIL bp_order idx=%0d got=%h want=%h", i, obs_q[i], acc_q[i]);
      end
    end
    $display("test_backpressure accepted=%0d drained=%0d", nacc, obs_q.size());
  endtask

  task automatic test_random;
    bit ok; bit done = 0; int st; int bad = 0;
    obs_q.delete(); acc_q.delete();
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          drive_edge(16'($urandom), 16'($urandom), 8'($urandom_range(0, 255)), (i == 999), ok, st);
          if (!ok) begin
            n_cmp++; n_bad++; $display("FAIL rnd_accept_timeout edge=%0d", i);
            break;
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          upd_ready = 1'($urandom % 2);
        end
      end
    join
    upd_ready = 1'b1;
    wait_idle(ok);
    n_cmp++; if (!ok || obs_q.size() != 1000 || acc_q.size() != 1000) begin
      n_bad++; $display("FAIL rnd_count got=%0d acc=%0d want=1000 idle=%b", obs_q.size(), acc_q.size(), ok);
    end
    for (int i = 0; i < obs_q.size() && i < acc_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== acc_q[i]) begin
        n_bad++; bad++;
        if (bad < 20) $display("FAIL rnd_item idx=%0d got=%h want=%h", i, obs_q[i], acc_q[i]);
      end
    end
    $display("test_random updates=%0d item_errors=%0d", obs_q.size(), bad);
  endtask

  task automatic test_reset_midflight;
    bit ok; int st;
    obs_q.delete(); acc_q.delete();
    upd_ready = 1'b0;
    for (int i = 0; i < 7; i++) drive_edge(16'(40 + i), 16'(60 + i), 8'd1, 1'b0, ok, st);
    n_cmp++; if (idle !== 1'b0 || upd_valid !== 1'b1) begin
      n_bad++; $display("FAIL mid_busy idle=%b valid=%b want idle=0 valid=1", idle, upd_valid);
    end
    rst = 1'b1;
    #1;
    obs_q.delete(); acc_q.delete();
    n_cmp++; if (upd_valid !== 1'b0 || idle !== 1'b1 || edge_ready !== 1'b0) begin
      n_bad++; $display("FAIL mid_rst valid=%b idle=%b ready=%b want 0/1/0", upd_valid, idle, edge_ready);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    upd_ready = 1'b1;
    repeat (20) @(negedge clk);
    n_cmp++; if (obs_q.size() != 0 || idle !== 1'b1) begin
      n_bad++; $display("FAIL mid_stale emitted=%0d idle=%b want 0 emitted idle=1", obs_q.size(), idle);
    end
    $display("test_reset_midflight stale_updates=%0d", obs_q.size());
  endtask

  initial begin
    rst = 1'b1;
    edge_src = '0; edge_dst = '0; edge_w = '0; edge_last = 1'b0; edge_valid = 1'b0;
    upd_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset;
    test_latency;
    test_saturation;
    test_back_to_back;
    test_backpressure;
    test_random;
    test_reset_midflight;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/scatter_update_gen.md
SCATTER_UPDATE_GEN -- requirements
Module: scatter_update_gen

Interface
REQ-001 Parameter DATA_W, default 8: vertex value and edge weight width, in bits.
REQ-002 Parameter ADDR_W, default 10: per-bank word address width; vertex index width is ADDR_W+6.
REQ-003 Parameter FIFO_DEPTH, default 8: output FIFO entries, power of two, minimum 4.
REQ-004 clk  input  1  single clock; all logic on posedge clk.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 edge_src  input  ADDR_W+6  source vertex index of the offered edge.
REQ-007 edge_dst  input  ADDR_W+6  destination vertex index of the offered edge.
REQ-008 edge_w  input  DATA_W  edge weight.
REQ-009 edge_last  input  1  marks the final edge of the partition.
REQ-010 edge_valid  input  1  edge offer qualifier.
REQ-011 edge_ready  output  1  block accepts the edge this cycle.
REQ-012 r_addr  output  ADDR_W+6  registered read index to the 64-bank vertex value memory.
REQ-013 vval_in  input  DATA_W  vertex value returned by the memory.
REQ-014 upd_dst  output  ADDR_W+6  destination vertex of the update.
REQ-015 upd_val  output  DATA_W  update value.
REQ-016 upd_last  output  1  update derives from an edge that had edge_last set.
REQ-017 upd_valid  output  1  update offer qualifier.
REQ-018 upd_ready  input  1  downstream accepts the update.
REQ-019 idle  output  1  no edge in flight and FIFO empty.

Function
REQ-020 An edge is accepted on a posedge where edge_valid and edge_ready are both high; r_addr loads edge_src on that edge and holds otherwise.
REQ-021 Memory read latency is fixed at 2: an edge accepted at posedge t has its vval_in valid during the cycle after t+2 and captured at t+3.
REQ-022 A 3-stage shadow pipeline (valid, dst, w, last) tracks each accepted edge; the memory path is never stalled.
REQ-023 upd_val = min(vval_in + edge_w, 2^DATA_W-1); add computed at DATA_W+1 bits, saturated.
REQ-024 Captured results enter the output FIFO in acceptance order; FIFO head drives upd_dst, upd_val, upd_last and upd_valid.
REQ-025 A FIFO entry pops on a posedge with upd_valid and upd_ready; upd_* stay stable while upd_valid is high and upd_ready is low.
REQ-026 edge_ready = (fifo_count + inflight) < FIFO_DEPTH, with inflight = number of set shadow-pipeline valids; FIFO overflow is therefore impossible.
REQ-027 Simultaneous push and pop on a full FIFO are both performed, and the count is unchanged.
REQ-028 FIFO read and write pointers wrap modulo FIFO_DEPTH.
REQ-029 Minimum accept-to-upd_valid latency is 3 cycles.
REQ-030 With upd_ready held high and FIFO_DEPTH >= 8, throughput is 1 edge per cycle.
REQ-031 idle is high when inflight == 0 and fifo_count == 0.

Reset
REQ-032 While rst is high: edge_ready=0, upd_valid=0, upd_last=0, upd_dst=0, upd_val=0, r_addr=0, idle=1, all pointers, counts and shadow valids are 0.
REQ-033 Reset asserted mid-operation discards all in-flight and queued updates; no update is emitted for them after release.
REQ-034 edge_ready rises on the first posedge after rst deasserts.

Structure
REQ-035 Package edge_pkg holds DATA_W/ADDR_W defaults, RD_LAT=2, and the update record typedef (dst, val, last).
REQ-036 The FIFO is one sub-module, update_fifo, with push/pop/count ports; everything else is in the top module.

Verification
REQ-037 Memory model value[v] = v[7:0]; edge src=5, dst=9, w=3, upd_ready=1 -> upd_val=8, upd_dst=9 exactly 3 cycles after acceptance.
REQ-038 src=250 (value 250), w=10 -> upd_val=255 (saturated); w=5 -> 255; w=4 -> 254.
REQ-039 Stream 100 back-to-back edges, upd_ready=1 -> edge_ready never drops, 100 updates emitted in order, last one with upd_last=1.
REQ-040 upd_ready=0, keep offering edges -> exactly 8 accepted, edge_ready=0 after that, outputs stable; raise upd_ready -> 8 updates drain in order, then accepts resume.
REQ-041 Random upd_ready at 50% with 1000 random edges -> scoreboard matches every update, no loss or duplication, pointers wrap cleanly.
REQ-042 Assert rst with 3 edges in flight and 4 queued -> upd_valid=0 immediately, idle=1, and no stale update is emitted after release.
